// File: rtl/gpio_debounce.sv
// Two-flop synchroniser plus tick-based debouncer for board inputs, with
// registered per-bit rise/fall pulses and a combined change flag.
module gpio_debounce #(
  parameter int unsigned      Width       = 14,
  parameter int unsigned      TickCycles  = 30_000,
  parameter int unsigned      StableTicks = 8,
  parameter logic [Width-1:0] ResetValue  = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] pad_i,
  input  logic             bypass_i,
  output logic [Width-1:0] out_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             change_o
);

  localparam int unsigned   PW      = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam int unsigned   CW      = $clog2(StableTicks + 1);
  localparam logic [PW-1:0] TickMax = PW'(TickCycles - 1);
  localparam logic [CW-1:0] CntMax  = CW'(StableTicks - 1);

  logic [Width-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q;
  logic             tick;
  logic [CW-1:0]    cnt_q [Width];
  logic [CW-1:0]    cnt_d [Width];
  logic [Width-1:0] out_d;

  // Sync flops reset to ResetValue so reset release never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ResetValue;
      sync2_q <= ResetValue;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  assign tick = (presc_q == TickMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_comb begin
    out_d = out_o;
    for (int unsigned i = 0; i < Width; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bypass_i) begin
        cnt_d[i] = '0;
        out_d[i] = sync2_q[i];
      end else if (sync2_q[i] == out_o[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntMax) begin
          out_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Edge flags are derived from the next-state value so they line up with
  // the first cycle out_o shows the new level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_o    <= ResetValue;
      rise_o   <= '0;
      fall_o   <= '0;
      change_o <= 1'b0;
      for (int unsigned i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_o    <= out_d;
      rise_o   <= ~out_o & out_d;
      fall_o   <= out_o & ~out_d;
      change_o <= |(out_o ^ out_d);
      for (int unsigned i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
